// File: rtl/uart_byte_tx_if.sv
// uart_byte_tx_if: byte handshake between the image sender and the UART
// transmitter, plus the serial line itself.
//
//   tx_data   byte to send, sampled when a request is accepted
//   txEn      transmit enable, qualifies txStart
//   txStart   start request (level, may be held through txDone)
//   txBusy    transmitter is shifting a frame
//   txDone    one-cycle pulse at frame completion
//   uart_txd  serial line, idle high
//
// master: the byte sender. slave: the transmitter.
interface uart_byte_tx_if;
    logic [7:0] tx_data;
    logic       txEn;
    logic       txStart;
    logic       txBusy;
    logic       txDone;
    logic       uart_txd;

    modport master (
        output tx_data, txEn, txStart,
        input  txBusy, txDone, uart_txd
    );

    modport slave (
        input  tx_data, txEn, txStart,
        output txBusy, txDone, uart_txd
    );
endinterface

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8-bit UART transmitter, LSB first, 1 or 2 stop bits.
// A rising edge of (txEn & txStart) while idle latches tx_data and sends a
// frame; a level-held request never retriggers.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    uart_byte_tx_if.slave (tx_data, txEn, txStart, txBusy, txDone, uart_txd)
//
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit(s).
//
// state  | meaning
// IDLE   | line high, waiting for a request rising edge
// START  | start bit (line low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit(s), line high
module uart_byte_tx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_byte_tx_if.slave bus
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end

    localparam int              CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
    } state_t;
`endif

    state_t           state, state_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [CNT_W-1:0] baud_cnt, cnt_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic             txd_r, txd_nxt;
    logic             busy_r, busy_nxt;
    logic             done_r, done_nxt;
    logic             req, req_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit, par_nxt;
`endif

    assign req     = bus.txEn & bus.txStart;
    assign bit_end = (baud_cnt == CNT_LAST);

    assign bus.uart_txd = txd_r;
    assign bus.txBusy   = busy_r;
    assign bus.txDone   = done_r;

    always_ff @(posedge clk) begin
        // req_d follows req even in reset, so a request already held high
        // when reset releases is not mistaken for a fresh rising edge.
        req_d <= req;
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            baud_cnt  <= cnt_nxt;
            bit_idx   <= idx_nxt;
            txd_r     <= txd_nxt;
            busy_r    <= busy_nxt;
            done_r    <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_bit <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_end ? '0 : baud_cnt + CNT_W'(1);
        idx_nxt   = bit_idx;
        txd_nxt   = txd_r;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt   = parity_bit;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (req && !req_d) begin
                    shift_nxt = bus.tx_data;
                    busy_nxt  = 1'b1;
                    txd_nxt   = 1'b0;
                    state_nxt = START;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = ^bus.tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    txd_nxt   = shift_reg[0];
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    // bit_idx wraps 7 -> 0, which also seeds the stop-bit count
                    idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        txd_nxt   = parity_bit;
`else
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
`endif
                    end else begin
                        txd_nxt   = shift_reg[0];
                        shift_nxt = {1'b0, shift_reg[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    txd_nxt   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        txd_nxt   = 1'b1;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
module tb_uart_byte_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam int DONE_CYC   = 45;
    localparam logic [11:0] A5_BITS = 12'b010101001010;
`else
    localparam int FRAME_BITS = 10;
    localparam int DONE_CYC   = 41;
    localparam logic [11:0] A5_BITS = 12'b001101001010;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    uart_byte_tx_if bus_if ();

    uart_byte_tx #(
        .CLK_FREQ (16),
        .BAUD     (4),
        .STOP_BITS(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // index i of every vector below corresponds to cycle i+1 after acceptance
    function automatic logic [63:0] exp_line(input logic [7:0] d);
        logic [63:0] v;
        int k;
        for (int c = 0; c < 64; c++) begin
            k = c / CPB;
            if (k == 0)      v[c] = 1'b0;
            else if (k <= 8) v[c] = d[k-1];
`ifdef UART_TX_PARITY_EN
            else if (k == 9) v[c] = ^d;
`endif
            else             v[c] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_busy();
        logic [63:0] v;
        for (int c = 0; c < 64; c++) v[c] = (c < FRAME_CYC);
        return v;
    endfunction

    function automatic logic [63:0] exp_done();
        logic [63:0] v;
        for (int c = 0; c < 64; c++) v[c] = (c == FRAME_CYC);
        return v;
    endfunction

    function automatic logic [63:0] mask(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic capture(input int n, output logic [63:0] l,
                           output logic [63:0] b, output logic [63:0] d);
        l = '0; b = '0; d = '0;
        for (int i = 0; i < n; i++) begin
            l[i] = bus_if.uart_txd;
            b[i] = bus_if.txBusy;
            d[i] = bus_if.txDone;
            tick();
        end
    endtask

    task automatic test_reset();
        logic seen_bad;
        rst_n = 1'b0;
        bus_if.txEn = 1'b1;
        bus_if.txStart = 1'b1;
        bus_if.tx_data = 8'h55;
        repeat (3) tick();
        total++;
        if (bus_if.uart_txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b want=1", bus_if.uart_txd); end
        total++;
        if (bus_if.txBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_if.txBusy); end
        total++;
        if (bus_if.txDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus_if.txDone); end
        rst_n = 1'b1;
        seen_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.uart_txd !== 1'b1 || bus_if.txBusy !== 1'b0) seen_bad = 1'b1;
        end
        total++;
        if (seen_bad !== 1'b0) begin bad++; $display("FAIL reset_held_req_no_frame got=%b want=0", seen_bad); end
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        logic [63:0] l, b, d;
        logic [11:0] s;
        bus_if.tx_data = 8'hA5;
        bus_if.txEn = 1'b1;
        bus_if.txStart = 1'b1;
        tick();
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        bus_if.tx_data = 8'h5A;
        capture(FRAME_CYC + 2, l, b, d);
        s = '0;
        for (int k = 0; k < FRAME_BITS; k++) s[k] = l[k*CPB + 1];
        total++;
        if (s !== A5_BITS) begin bad++; $display("FAIL single_bits got=%b want=%b", s, A5_BITS); end
        total++;
        if (l !== (exp_line(8'hA5) & mask(FRAME_CYC + 2))) begin bad++; $display("FAIL single_line got=%h want=%h", l, exp_line(8'hA5) & mask(FRAME_CYC + 2)); end
        total++;
        if (b !== (exp_busy() & mask(FRAME_CYC + 2))) begin bad++; $display("FAIL single_busy got=%h want=%h", b, exp_busy() & mask(FRAME_CYC + 2)); end
        total++;
        if (d !== (exp_done() & mask(FRAME_CYC + 2))) begin bad++; $display("FAIL single_done got=%h want=%h", d, exp_done() & mask(FRAME_CYC + 2)); end
        total++;
        if (d[DONE_CYC-1] !== 1'b1) begin bad++; $display("FAIL single_done_cycle got=%b want=1", d[DONE_CYC-1]); end
    endtask

    task automatic test_held_request();
        logic [63:0] l, b, d;
        bus_if.tx_data = 8'hC3;
        bus_if.txEn = 1'b1;
        bus_if.txStart = 1'b1;
        tick();
        capture(FRAME_CYC + 3, l, b, d);
        total++;
        if (l !== (exp_line(8'hC3) & mask(FRAME_CYC + 3))) begin bad++; $display("FAIL held_line got=%h want=%h", l, exp_line(8'hC3) & mask(FRAME_CYC + 3)); end
        total++;
        if (b !== (exp_busy() & mask(FRAME_CYC + 3))) begin bad++; $display("FAIL held_busy got=%h want=%h", b, exp_busy() & mask(FRAME_CYC + 3)); end
        total++;
        if (d !== (exp_done() & mask(FRAME_CYC + 3))) begin bad++; $display("FAIL held_done got=%h want=%h", d, exp_done() & mask(FRAME_CYC + 3)); end
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] l1, b1, d1, l2, b2, d2;
        logic [1:0] gap;
        bus_if.tx_data = 8'h00;
        bus_if.txEn = 1'b1;
        bus_if.txStart = 1'b1;
        tick();
        capture(FRAME_CYC + 1, l1, b1, d1);
        bus_if.txStart = 1'b0;
        gap[0] = bus_if.uart_txd;
        tick();
        bus_if.tx_data = 8'hFF;
        bus_if.txStart = 1'b1;
        gap[1] = bus_if.uart_txd;
        tick();
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        capture(FRAME_CYC + 2, l2, b2, d2);
        total++;
        if (l1 !== (exp_line(8'h00) & mask(FRAME_CYC + 1))) begin bad++; $display("FAIL b2b_line1 got=%h want=%h", l1, exp_line(8'h00) & mask(FRAME_CYC + 1)); end
        total++;
        if (d1[FRAME_CYC] !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b want=1", d1[FRAME_CYC]); end
        total++;
        if (gap !== 2'b11) begin bad++; $display("FAIL b2b_gap got=%b want=11", gap); end
        total++;
        if (l2 !== (exp_line(8'hFF) & mask(FRAME_CYC + 2))) begin bad++; $display("FAIL b2b_line2 got=%h want=%h", l2, exp_line(8'hFF) & mask(FRAME_CYC + 2)); end
        total++;
        if (d2 !== (exp_done() & mask(FRAME_CYC + 2))) begin bad++; $display("FAIL b2b_done2 got=%h want=%h", d2, exp_done() & mask(FRAME_CYC + 2)); end
    endtask

    task automatic test_busy_abort();
        logic [63:0] l, b, d;
        logic pre, seen_bad;
        bus_if.tx_data = 8'hA5;
        bus_if.txEn = 1'b1;
        bus_if.txStart = 1'b1;
        tick();
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        fork
            capture(FRAME_CYC + 2, l, b, d);
            begin
                repeat (9) tick();
                bus_if.tx_data = 8'h3C;
                bus_if.txEn = 1'b1;
                bus_if.txStart = 1'b1;
                repeat (2) tick();
                bus_if.txEn = 1'b0;
                bus_if.txStart = 1'b0;
            end
        join
        total++;
        if (l !== (exp_line(8'hA5) & mask(FRAME_CYC + 2))) begin bad++; $display("FAIL busy_ignore_line got=%h want=%h", l, exp_line(8'hA5) & mask(FRAME_CYC + 2)); end
        total++;
        if (d !== (exp_done() & mask(FRAME_CYC + 2))) begin bad++; $display("FAIL busy_ignore_done got=%h want=%h", d, exp_done() & mask(FRAME_CYC + 2)); end
        // 0x81: cycle 20 carries data bit 3 = 0, so the abort is visible
        bus_if.tx_data = 8'h81;
        bus_if.txEn = 1'b1;
        bus_if.txStart = 1'b1;
        tick();
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        repeat (19) tick();
        pre = bus_if.uart_txd;
        rst_n = 1'b0;
        tick();
        total++;
        if (pre !== 1'b0) begin bad++; $display("FAIL abort_pre_line got=%b want=0", pre); end
        total++;
        if (bus_if.uart_txd !== 1'b1) begin bad++; $display("FAIL abort_line got=%b want=1", bus_if.uart_txd); end
        total++;
        if (bus_if.txBusy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus_if.txBusy); end
        seen_bad = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < FRAME_CYC + 4; i++) begin
            if (bus_if.txDone !== 1'b0 || bus_if.uart_txd !== 1'b1 || bus_if.txBusy !== 1'b0) seen_bad = 1'b1;
            tick();
        end
        total++;
        if (seen_bad !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", seen_bad); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [63:0] l, b, d;
        bus_if.tx_data = 8'hA5;
        bus_if.txEn = 1'b1;
        bus_if.txStart = 1'b1;
        tick();
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        capture(FRAME_CYC + 2, l, b, d);
        total++;
        if (l[39:36] !== 4'b0000) begin bad++; $display("FAIL parity_a5 got=%b want=0000", l[39:36]); end
        total++;
        if (d[44] !== 1'b1) begin bad++; $display("FAIL parity_a5_done got=%b want=1", d[44]); end
        bus_if.tx_data = 8'h01;
        bus_if.txEn = 1'b1;
        bus_if.txStart = 1'b1;
        tick();
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        capture(FRAME_CYC + 2, l, b, d);
        total++;
        if (l[39:36] !== 4'b1111) begin bad++; $display("FAIL parity_01 got=%b want=1111", l[39:36]); end
        total++;
        if (l !== (exp_line(8'h01) & mask(FRAME_CYC + 2))) begin bad++; $display("FAIL parity_01_line got=%h want=%h", l, exp_line(8'h01) & mask(FRAME_CYC + 2)); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        bus_if.tx_data = 8'h00;
        bus_if.txEn = 1'b0;
        bus_if.txStart = 1'b0;
        test_reset();
        test_single_byte();
        test_held_request();
        test_back_to_back();
        test_busy_abort();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
